// File: rtl/tc_sram_handshake.sv
// Valid/ready front end for a fixed-latency single-port SRAM.
// Read data lands in a response FIFO. Credits reserve FIFO space at accept time, so no response can be lost.
module tc_sram_handshake #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = 4,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);
   localparam int unsigned CntWidth = $clog2(RspDepth + 1);
   localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

   logic [CntWidth-1:0]                cnt_q, cnt_d;
   logic [CntWidth-1:0]                fill_q, fill_d;
   logic [PtrWidth-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]                rd_ptr_q, rd_ptr_d;
   logic [RspDepth-1:0][DataWidth-1:0] mem_q, mem_d;
   logic                               accept, rd_accept, pipe_out, pop;

   // Ready depends on credits alone, never on the incoming request.
   assign req_ready_o = (cnt_q < CntWidth'(RspDepth));
   assign accept      = req_valid_i & req_ready_o;
   assign rd_accept   = accept & ~req_we_i;

   assign sram_req_o   = accept;
   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = req_we_i ? req_be_i : '0;

   assign rsp_valid_o = (fill_q != '0);
   assign rsp_rdata_o = mem_q[rd_ptr_q];
   assign pop         = rsp_valid_o & rsp_ready_i;

   generate
      if (Latency == 0) begin : g_no_pipe
         assign pipe_out = rd_accept;
      end else begin : g_pipe
         logic [Latency-1:0] vld_pipe_q, vld_pipe_d;

         always_comb begin
            vld_pipe_d = (vld_pipe_q << 1) | Latency'(rd_accept);
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) vld_pipe_q <= '0;
            else         vld_pipe_q <= vld_pipe_d;
         end

         assign pipe_out = vld_pipe_q[Latency-1];
      end
   endgenerate

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (pipe_out) begin
         mem_d[wr_ptr_q] = sram_rdata_i;
         wr_ptr_d = (wr_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      fill_d = fill_q + CntWidth'(pipe_out) - CntWidth'(pop);
      // A credit covers a read from accept until its response leaves the FIFO.
      cnt_d  = cnt_q + CntWidth'(rd_accept) - CntWidth'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         fill_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         fill_q   <= fill_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

`ifndef SYNTHESIS
   property p_req_stable;
      @(posedge clk_i) disable iff (!rst_ni)
         (req_valid_i && !req_ready_o) |=>
            (req_valid_i && $stable(req_we_i) && $stable(req_addr_i) &&
             $stable(req_wdata_i) && $stable(req_be_i));
   endproperty
   a_req_stable: assert property (p_req_stable)
      else $error("request changed while stalled");

   generate
      if (NumWords < (1 << AddrWidth)) begin : g_oor_chk
         always @(posedge clk_i) begin
            if (rst_ni && accept && (req_addr_i >= AddrWidth'(NumWords)))
               $warning("address %0d beyond %0d words", req_addr_i, NumWords);
         end
      end
   endgenerate
`endif
endmodule

// File: tb/tb_tc_sram_handshake.sv
// Drives four latency/depth configurations of the adapter with directed and random traffic.
// A timestamped response queue predicts every output.
module tb_tc_sram_handshake;
   localparam int NW = 256;
   localparam int AW = 8;

   typedef struct {
      longint   due;
      bit [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   for (genvar G = 0; G < 4; G++) begin : cfg
      localparam int L    = (G == 0) ? 1 : (G == 1) ? 2 : (G == 2) ? 0 : 2;
      localparam int D    = (G == 0) ? 4 : (G == 1) ? 4 : (G == 2) ? 2 : 3;
      localparam int LP   = (L > 0) ? L : 1;
      localparam int NR   = (D < 3) ? D : 3;
      localparam bit FULL = (D >= L + 2);

      logic          rst_n;
      logic          req_valid, req_ready, req_we;
      logic [AW-1:0] req_addr;
      logic [31:0]   req_wdata;
      logic [3:0]    req_be;
      logic          rsp_valid, rsp_ready;
      logic [31:0]   rsp_rdata;
      logic          sram_req, sram_we;
      logic [AW-1:0] sram_addr;
      logic [31:0]   sram_wdata, sram_rdata;
      logic [3:0]    sram_be;
      bit            done;
      bit            rand_rdy;
      longint        cyc = 0;

      tc_sram_handshake #(
         .NumWords(NW), .DataWidth(32), .ByteWidth(8), .Latency(L), .RspDepth(D)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
         .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
         .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
         .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
         .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
      );

      // SRAM behaviour: zero-initialised, byte-masked writes, data L cycles after the read.
      bit [31:0] smem  [NW];
      bit [31:0] rpipe [LP];

      always @(posedge clk) begin
         if (sram_req && sram_we)
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) smem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         if (sram_req && !sram_we) rpipe[0] <= smem[sram_addr];
         for (int i = 1; i < LP; i++) rpipe[i] <= rpipe[i-1];
      end

      assign sram_rdata = (L == 0) ? smem[sram_addr] : rpipe[LP-1];

      // Reference: reads retire in accept order, visible L+1 cycles after acceptance;
      // at most D reads may be in flight.
      bit [31:0] shm [NW];
      exp_t      q[$];

      initial forever begin
         bit e_rdy, e_vld, acc;
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            check($sformatf("c%0d rst rsp_valid", G), rsp_valid, 0);
            check($sformatf("c%0d rst req_ready", G), req_ready, 1);
            check($sformatf("c%0d rst rsp_rdata", G), rsp_rdata, 0);
            check($sformatf("c%0d rst sram_req", G), sram_req, req_valid);
         end else begin
            e_rdy = (q.size() < D);
            e_vld = (q.size() != 0) && (q[0].due <= cyc);
            acc   = req_valid && e_rdy;
            check($sformatf("c%0d req_ready", G), req_ready, e_rdy);
            check($sformatf("c%0d rsp_valid", G), rsp_valid, e_vld);
            check($sformatf("c%0d sram_req", G), sram_req, acc);
            if (e_vld) check($sformatf("c%0d rsp_rdata", G), rsp_rdata, q[0].data);
            if (acc) begin
               check($sformatf("c%0d sram_addr", G), sram_addr, req_addr);
               check($sformatf("c%0d sram_we", G), sram_we, req_we);
               check($sformatf("c%0d sram_wdata", G), sram_wdata, req_wdata);
               check($sformatf("c%0d sram_be", G), sram_be, req_we ? req_be : 4'h0);
               if (req_we) begin
                  for (int b = 0; b < 4; b++)
                     if (req_be[b]) shm[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
               end else begin
                  q.push_back('{due: cyc + L + 1, data: shm[req_addr]});
               end
            end
            if (e_vld && rsp_ready) void'(q.pop_front());
         end
         cyc++;
      end

      task automatic tick();
         @(posedge clk); #1;
         if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      endtask

      task automatic idle(input int n);
         for (int i = 0; i < n; i++) tick();
      endtask

      task automatic do_req(input bit we, input int a, input logic [31:0] d, input logic [3:0] b);
         int n = 0;
         bit r = 0;
         req_valid = 1; req_we = we; req_addr = a[AW-1:0]; req_wdata = d; req_be = b;
         while (!r && n < 200) begin
            @(negedge clk);
            r = req_ready;
            tick();
            n++;
         end
         if (!r) check($sformatf("c%0d accept timeout", G), req_ready, 1);
         req_valid = 0;
      endtask

      task automatic wait_rsp(input string nm, input logic [31:0] exp_d, input int exp_lat);
         int k = 0;
         while (k < 50) begin
            @(negedge clk);
            if (rsp_valid) break;
            k++;
         end
         check($sformatf("c%0d %s valid", G, nm), rsp_valid, 1);
         check($sformatf("c%0d %s data", G, nm), rsp_rdata, exp_d);
         if (exp_lat >= 0) check($sformatf("c%0d %s latency", G, nm), k, exp_lat);
         tick();
      endtask

      initial begin
         longint start;
         rst_n = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
         rsp_ready = 1; rand_rdy = 0;
         #1 rst_n = 0;
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("c%0d reset ready", G), req_ready, 1);
         check($sformatf("c%0d reset valid", G), rsp_valid, 0);
         check($sformatf("c%0d reset sram_req", G), sram_req, 0);
         rst_n = 1;
         tick();

         do_req(1, 5, 32'hDEADBEEF, 4'hF);
         idle(L + 2);
         check($sformatf("c%0d no rsp for write", G), rsp_valid, 0);
         do_req(0, 5, 32'h0, 4'h0);
         wait_rsp("rd5", 32'hDEADBEEF, L);

         do_req(1, 3, 32'hFFFFFFFF, 4'hF);
         do_req(1, 3, 32'h00000000, 4'h5);
         do_req(0, 3, 32'h0, 4'h0);
         wait_rsp("be", 32'hFF00FF00, L);

         for (int a = 0; a < 6; a++) do_req(1, a, 32'hA0000000 | a, 4'hF);
         rsp_ready = 0;
         for (int a = 0; a < D; a++) do_req(0, a, 32'h0, 4'h0);
         idle(L + 2);
         check($sformatf("c%0d bp ready low", G), req_ready, 0);
         rsp_ready = 1;
         wait_rsp("bp first", 32'hA0000000, -1);
         for (int a = D; a < 6; a++) do_req(0, a, 32'h0, 4'h0);
         idle(L + D + 4);
         check($sformatf("c%0d bp drained", G), rsp_valid, 0);

         for (int a = 0; a < 100; a++) do_req(1, 100 + a, 32'h50000000 + a, 4'hF);
         start = cyc;
         for (int a = 0; a < 100; a++) do_req(0, 100 + a, 32'h0, 4'h0);
         check($sformatf("c%0d stream stalled", G), (cyc - start) > 100, !FULL);
         idle(L + D + 4);

         rand_rdy = 1;
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            do_req($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
         end
         rand_rdy = 0;
         rsp_ready = 1;
         idle(L + D + 4);
         check($sformatf("c%0d rand drained", G), rsp_valid, 0);

         rsp_ready = 0;
         for (int a = 0; a < NR; a++) do_req(0, 100 + a, 32'h0, 4'h0);
         rst_n = 0;
         @(negedge clk);
         check($sformatf("c%0d midrst valid", G), rsp_valid, 0);
         check($sformatf("c%0d midrst ready", G), req_ready, 1);
         @(posedge clk); #1;
         rst_n = 1;
         rsp_ready = 1;
         idle(L + 5);
         check($sformatf("c%0d no stale rsp", G), rsp_valid, 0);
         check($sformatf("c%0d post rst ready", G), req_ready, 1);
         done = 1;
      end
   end

   initial begin
      wait (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
